sipo_align_ctrl: RTL

Word-alignment controller for the 10-bit serial-to-parallel converter. Watches the converter's sliding 10-bit window every clock, hunts for the 8b/10b K28.5 comma, establishes and verifies the word boundary, then emits one aligned 10-bit word per 10 bit-times with a valid strobe. Sits directly after `sipo_10bits_cond` (its `Pdata` drives `window`) and ahead of the 8b/10b decoder.

---
 rtl/sipo_align_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sipo_align_ctrl.sv
// K28.5 word-alignment controller: hunts for the comma in the SIPO window, verifies the boundary, emits aligned words.
// Optional `SIPO_ALIGN_ERRCNT_EN adds a saturating misaligned-comma counter output err_cnt.
module sipo_align_ctrl #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4,
  parameter logic [9:0]  COMMA_N  = 10'b0011111010,
  parameter logic [9:0]  COMMA_P  = 10'b1100000101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [9:0] window,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       k_comma,
  output logic       locked,
`ifdef SIPO_ALIGN_ERRCNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic [1:0] state
);

  localparam int unsigned WORD_W  = 10;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned GOOD_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W  = $clog2(LOSS_CNT + 1);
  localparam int unsigned ERR_W   = 8;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_VERIFY  = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
  logic [LOSS_W-1:0]   loss_cnt_q, loss_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                word_valid_q, word_valid_d;
  logic                k_comma_q, k_comma_d;
  logic                locked_q, locked_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

  logic comma_c;
  logic boundary_c;

  assign comma_c    = (window == COMMA_N) || (window == COMMA_P);
  assign boundary_c = (phase_q == PHASE_W'(9));

  // Next-state, counters and output word capture
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    good_cnt_d   = good_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    word_d       = word_q;
    k_comma_d    = k_comma_q;
    word_valid_d = 1'b0;
    err_cnt_d    = err_cnt_q;

    if (state_q == ST_ILLEGAL) begin
      state_d    = ST_HUNT;
      good_cnt_d = '0;
      loss_cnt_d = '0;
    end else if (en) begin
      phase_d = boundary_c ? '0 : phase_q + PHASE_W'(1);
      unique case (state_q)
        ST_HUNT: begin
          if (comma_c) begin
            phase_d    = '0;
            good_cnt_d = GOOD_W'(1);
            loss_cnt_d = '0;
            state_d    = (LOCK_CNT <= 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (comma_c && boundary_c) begin
            if (32'(good_cnt_q) + 32'd1 >= LOCK_CNT) begin
              good_cnt_d = GOOD_W'(LOCK_CNT);
              loss_cnt_d = '0;
              state_d    = ST_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else if (comma_c) begin
            // Comma off the expected boundary: trust the newest one
            phase_d    = '0;
            good_cnt_d = GOOD_W'(1);
          end
        end
        ST_LOCKED: begin
          if (boundary_c) begin
            word_d       = window;
            k_comma_d    = comma_c;
            word_valid_d = 1'b1;
            if (comma_c) loss_cnt_d = '0;
          end else if (comma_c) begin
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (32'(loss_cnt_q) + 32'd1 >= LOSS_CNT) begin
              loss_cnt_d = LOSS_W'(LOSS_CNT);
              good_cnt_d = '0;
              state_d    = ST_HUNT;
            end else begin
              loss_cnt_d = loss_cnt_q + LOSS_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HUNT;
      phase_q      <= '0;
      good_cnt_q   <= '0;
      loss_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      k_comma_q    <= 1'b0;
      locked_q     <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      good_cnt_q   <= good_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      k_comma_q    <= k_comma_d;
      locked_q     <= locked_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign k_comma    = k_comma_q;
  assign locked     = locked_q;
  assign state      = state_q;

`ifdef SIPO_ALIGN_ERRCNT_EN
  assign err_cnt = err_cnt_q;
`else
  logic unused_err_c;
  assign unused_err_c = ^err_cnt_q;
`endif

endmodule
